mem_access_stage: RTL

- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Runs loads and stores against an external data memory with variable latency, using a req/ack handshake.
- Asserts STALL to freeze upstream stages until each access completes.
- Registers the MEM/WB results (write-back data, enable, destination) for the register file.

---
 rtl/mem_access_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ack data-memory access with upstream stall and MEM/WB register.
// Define MEM_ACCESS_TIMEOUT_EN to abort accesses left unacknowledged for TIMEOUT WAIT cycles.
module mem_access_stage #(
  parameter int DW      = 32,
  parameter int AW      = 16,
  parameter int RA      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MEM_DM_WE,
  input  logic [DW-1:0] MEM_ALU_RES,
  input  logic [DW-1:0] MEM_muxB,
  input  logic [AW-1:0] MEM_DM_ADDR,
  input  logic          MEM_RF_D_SEL,
  input  logic          MEM_RF_WE,
  input  logic [RA-1:0] MEM_RF_WA,
  output logic          DM_REQ,
  output logic          DM_WR,
  output logic [AW-1:0] DM_ADDR,
  output logic [DW-1:0] DM_WDATA,
  input  logic          DM_ACK,
  input  logic [DW-1:0] DM_RDATA,
  output logic          STALL,
  output logic [DW-1:0] WB_RF_DATA,
  output logic          WB_RF_WE,
  output logic [RA-1:0] WB_RF_WA,
  output logic          DM_ERR
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] rdata;
  logic          mem_op;

  assign mem_op = MEM_DM_WE | MEM_RF_D_SEL;

  // DONE deliberately drops the stall so EX/MEM advances past this access.
  assign STALL = !rst &&
                 ((state == IDLE && mem_op) ||
                  state == WAIT);

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err;
  assign DM_ERR = err;
`else
  assign DM_ERR = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      DM_REQ   <= 1'b0;
      DM_WR    <= 1'b0;
      DM_ADDR  <= '0;
      DM_WDATA <= '0;
      rdata    <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt      <= '0;
      err      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op) begin
            DM_REQ   <= 1'b1;
            DM_WR    <= MEM_DM_WE;
            DM_ADDR  <= MEM_DM_ADDR;
            DM_WDATA <= MEM_muxB;
            state    <= WAIT;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt      <= '0;
`endif
          end
        end
        WAIT: begin
          if (DM_ACK) begin
            rdata  <= DM_RDATA;
            DM_REQ <= 1'b0;
            state  <= DONE;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            cnt    <= cnt + CW'(1);
            rdata  <= '0;
            DM_REQ <= 1'b0;
            err    <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WB_RF_DATA <= '0;
      WB_RF_WE   <= 1'b0;
      WB_RF_WA   <= '0;
    end else if (STALL) begin
      WB_RF_WE <= 1'b0;
    end else begin
      WB_RF_WA   <= MEM_RF_WA;
      WB_RF_WE   <= MEM_RF_WE;
      WB_RF_DATA <= MEM_RF_D_SEL ? rdata : MEM_ALU_RES;
    end
  end

endmodule
